// File: rtl/ysyx_24110015_ctrl_pkg.sv
// Shared types for the multi-cycle core sequencer: controller state encoding and trap causes.
package ysyx_24110015_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_IF   = 3'd1,
    ST_ID   = 3'd2,
    ST_EX   = 3'd3,
    ST_LS   = 3'd4,
    ST_WB   = 3'd5,
    ST_TRAP = 3'd6
  } state_e;

  localparam logic [1:0] CAUSE_IF_ERR = 2'd0;
  localparam logic [1:0] CAUSE_LS_ERR = 2'd1;
  localparam logic [1:0] CAUSE_IF_TO  = 2'd2;
  localparam logic [1:0] CAUSE_LS_TO  = 2'd3;

endpackage

// File: rtl/ysyx_24110015_wait_timer.sv
// Bus-wait timeout counter shared by the IF and LS wait states.
// Saturating count; fires on the TO_CYC-th consecutive wait cycle (TO_CYC=0 disables it).
module ysyx_24110015_wait_timer #(
  parameter int TO_W   = 8,
  parameter int TO_CYC = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic fire_o
);

  localparam logic [TO_W-1:0] LAST = TO_W'(TO_CYC - 1);

  logic [TO_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign fire_o = (TO_CYC != 0) && en_i && (cnt_q == LAST);

endmodule

// File: rtl/ysyx_24110015_mc_sequencer.sv
// Multi-cycle core sequencer: IF/ID/EX/LS/WB/TRAP control with bus error and timeout trapping.
// Optional performance counters are built only when CTRL_PERF_EN is defined.
module ysyx_24110015_mc_sequencer
  import ysyx_24110015_ctrl_pkg::*;
#(
  parameter int TO_W   = 8,
  parameter int TO_CYC = 200,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              halt_i,
  input  logic              ifu_done_i,
  input  logic              ifu_err_i,
  input  logic              dec_ls_i,
  input  logic              dec_multi_i,
  input  logic              dec_wen_i,
  input  logic              ex_done_i,
  input  logic              lsu_done_i,
  input  logic              lsu_err_i,
  output logic              ifu_req_o,
  output logic              ex_start_o,
  output logic              lsu_req_o,
  output logic              reg_we_o,
  output logic              pc_we_o,
  output logic              commit_o,
  output logic              trap_o,
  output logic [1:0]        trap_cause_o,
  output logic              busy_o,
  output logic [PERF_W-1:0] perf_cyc_o,
  output logic [PERF_W-1:0] perf_ret_o,
  output logic [PERF_W-1:0] perf_stall_o
);

  state_e     state_q, state_d;
  logic       entered_q, entered_d;
  logic       dec_wen_q, dec_wen_d;
  logic [1:0] cause_q, cause_d;
  logic       waiting, wait_done, to_clr, to_en, to_fire;

  assign waiting   = (state_q == ST_IF) || (state_q == ST_LS);
  assign wait_done = (state_q == ST_IF) ? ifu_done_i : lsu_done_i;
  assign to_en     = waiting && !wait_done;
  assign to_clr    = entered_d && ((state_d == ST_IF) || (state_d == ST_LS));

  ysyx_24110015_wait_timer #(
    .TO_W  (TO_W),
    .TO_CYC(TO_CYC)
  ) u_wait_timer (
    .clk   (clk),
    .rst   (rst),
    .clr_i (to_clr),
    .en_i  (to_en),
    .fire_o(to_fire)
  );

  // Error beats done, done beats timeout in both wait states.
  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    dec_wen_d = dec_wen_q;
    case (state_q)
      ST_IDLE: if (!halt_i) state_d = ST_IF;
      ST_IF: begin
        if (ifu_err_i) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_IF_ERR;
        end else if (ifu_done_i) begin
          state_d = ST_ID;
        end else if (to_fire) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_IF_TO;
        end
      end
      ST_ID: begin
        dec_wen_d = dec_wen_i;
        if (dec_ls_i)         state_d = ST_LS;
        else if (dec_multi_i) state_d = ST_EX;
        else                  state_d = ST_WB;
      end
      ST_EX: if (ex_done_i) state_d = ST_WB;
      ST_LS: begin
        if (lsu_err_i) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_LS_ERR;
        end else if (lsu_done_i) begin
          state_d = ST_WB;
        end else if (to_fire) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_LS_TO;
        end
      end
      ST_WB, ST_TRAP: state_d = halt_i ? ST_IDLE : ST_IF;
      default: state_d = ST_IDLE;
    endcase
    entered_d = (state_d != state_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      entered_q <= 1'b0;
      dec_wen_q <= 1'b0;
      cause_q   <= CAUSE_IF_ERR;
    end else begin
      state_q   <= state_d;
      entered_q <= entered_d;
      dec_wen_q <= dec_wen_d;
      cause_q   <= cause_d;
    end
  end

  // Request pulses fire only on the first cycle after entering their state.
  assign ifu_req_o    = (state_q == ST_IF) && entered_q;
  assign ex_start_o   = (state_q == ST_EX) && entered_q;
  assign lsu_req_o    = (state_q == ST_LS) && entered_q;
  assign reg_we_o     = (state_q == ST_WB) && dec_wen_q;
  assign pc_we_o      = (state_q == ST_WB) || (state_q == ST_TRAP);
  assign commit_o     = (state_q == ST_WB);
  assign trap_o       = (state_q == ST_TRAP);
  assign trap_cause_o = cause_q;
  assign busy_o       = (state_q != ST_IDLE);

`ifdef CTRL_PERF_EN
  logic [PERF_W-1:0] cyc_q, cyc_d, ret_q, ret_d, stall_q, stall_d;

  always_comb begin
    cyc_d   = cyc_q + 1'b1;
    ret_d   = ret_q + PERF_W'(commit_o);
    stall_d = stall_q + PERF_W'(to_en);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q   <= '0;
      ret_q   <= '0;
      stall_q <= '0;
    end else begin
      cyc_q   <= cyc_d;
      ret_q   <= ret_d;
      stall_q <= stall_d;
    end
  end

  assign perf_cyc_o   = cyc_q;
  assign perf_ret_o   = ret_q;
  assign perf_stall_o = stall_q;
`else
  assign perf_cyc_o   = '0;
  assign perf_ret_o   = '0;
  assign perf_stall_o = '0;
`endif

endmodule

// File: tb/tb_ysyx_24110015_mc_sequencer.sv
// Bench for ysyx_24110015_mc_sequencer: instruction-level schedule builds a per-cycle
// {inputs, expected outputs} table that is then applied and compared cycle by cycle.
module tb_ysyx_24110015_mc_sequencer;

  localparam int TO_W_T   = 8;
  localparam int TO_CYC_T = 4;
  localparam int PERF_W_T = 32;

  logic clk = 1'b0;
  logic rst;
  logic halt_i, ifu_done_i, ifu_err_i, dec_ls_i, dec_multi_i, dec_wen_i;
  logic ex_done_i, lsu_done_i, lsu_err_i;
  logic ifu_req_o, ex_start_o, lsu_req_o, reg_we_o, pc_we_o, commit_o, trap_o, busy_o;
  logic [1:0] trap_cause_o;
  logic [PERF_W_T-1:0] perf_cyc_o, perf_ret_o, perf_stall_o;

  always #5 clk = ~clk;

  ysyx_24110015_mc_sequencer #(
    .TO_W  (TO_W_T),
    .TO_CYC(TO_CYC_T),
    .PERF_W(PERF_W_T)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .halt_i      (halt_i),
    .ifu_done_i  (ifu_done_i),
    .ifu_err_i   (ifu_err_i),
    .dec_ls_i    (dec_ls_i),
    .dec_multi_i (dec_multi_i),
    .dec_wen_i   (dec_wen_i),
    .ex_done_i   (ex_done_i),
    .lsu_done_i  (lsu_done_i),
    .lsu_err_i   (lsu_err_i),
    .ifu_req_o   (ifu_req_o),
    .ex_start_o  (ex_start_o),
    .lsu_req_o   (lsu_req_o),
    .reg_we_o    (reg_we_o),
    .pc_we_o     (pc_we_o),
    .commit_o    (commit_o),
    .trap_o      (trap_o),
    .trap_cause_o(trap_cause_o),
    .busy_o      (busy_o),
    .perf_cyc_o  (perf_cyc_o),
    .perf_ret_o  (perf_ret_o),
    .perf_stall_o(perf_stall_o)
  );

  typedef struct packed {
    logic       halt, ifu_done, ifu_err, dec_ls, dec_multi, dec_wen, ex_done, lsu_done, lsu_err;
    logic       ifu_req, ex_start, lsu_req, reg_we, pc_we, commit, trap, busy;
    logic [1:0] cause;
    logic       stall;
  } vec_t;

  vec_t       tbl[$];
  logic [1:0] cur_cause;
  bit         force_halt;
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", nm, idx, act, exp);
    end
  endtask

  // Random inputs everywhere, expected outputs idle; callers override what matters.
  function automatic vec_t noise();
    vec_t v;
    logic [8:0] r;
    v = '0;
    r = 9'($urandom);
    v.halt = force_halt ? 1'b1 : r[0];
    v.ifu_done = r[1]; v.ifu_err = r[2]; v.dec_ls = r[3]; v.dec_multi = r[4];
    v.dec_wen = r[5]; v.ex_done = r[6]; v.lsu_done = r[7]; v.lsu_err = r[8];
    v.cause = cur_cause;
    return v;
  endfunction

  // kind: 0 done on cycle n, 1 err on cycle n, 2 err+done on cycle n, 3 silent until timeout
  task automatic gen_wait(input bit is_ls, input int kind, input int n, output bit trapped);
    int len;
    vec_t v;
    len = (kind == 3) ? TO_CYC_T : n;
    for (int i = 1; i <= len; i++) begin
      v = noise();
      v.busy = 1'b1;
      if (is_ls) begin
        v.lsu_req = (i == 1);
        v.lsu_done = (i == len) && (kind == 0 || kind == 2);
        v.lsu_err = (i == len) && (kind == 1 || kind == 2);
        v.stall = !v.lsu_done;
      end else begin
        v.ifu_req = (i == 1);
        v.ifu_done = (i == len) && (kind == 0 || kind == 2);
        v.ifu_err = (i == len) && (kind == 1 || kind == 2);
        v.stall = !v.ifu_done;
      end
      tbl.push_back(v);
    end
    trapped = (kind != 0);
    if (trapped) cur_cause = is_ls ? ((kind == 3) ? 2'd3 : 2'd1) : ((kind == 3) ? 2'd2 : 2'd0);
  endtask

  task automatic gen_end(input bit trap, input bit wen, input int idle_n);
    vec_t v;
    v = noise();
    v.busy = 1'b1;
    v.pc_we = 1'b1;
    v.trap = trap;
    v.commit = !trap;
    v.reg_we = !trap && wen;
    v.halt = (idle_n > 0);
    tbl.push_back(v);
    for (int i = 1; i <= idle_n; i++) begin
      v = noise();
      v.halt = (i < idle_n);
      tbl.push_back(v);
    end
  endtask

  task automatic gen_instr(input int if_kind, input int if_n, input bit ls, input bit multi,
                           input bit wen, input int ex_n, input int ls_kind, input int ls_n,
                           input int idle_n);
    bit tr;
    vec_t v;
    gen_wait(1'b0, if_kind, if_n, tr);
    if (tr) begin
      gen_end(1'b1, 1'b0, idle_n);
      return;
    end
    v = noise();
    v.busy = 1'b1;
    v.dec_ls = ls; v.dec_multi = multi; v.dec_wen = wen;
    tbl.push_back(v);
    if (ls) begin
      gen_wait(1'b1, ls_kind, ls_n, tr);
      if (tr) begin
        gen_end(1'b1, 1'b0, idle_n);
        return;
      end
    end else if (multi) begin
      for (int i = 1; i <= ex_n; i++) begin
        v = noise();
        v.busy = 1'b1;
        v.ex_start = (i == 1);
        v.ex_done = (i == ex_n);
        tbl.push_back(v);
      end
    end
    gen_end(1'b0, wen, idle_n);
  endtask

  function automatic int pick_kind();
    int r;
    r = $urandom_range(0, 9);
    return (r < 7) ? 0 : (r - 6);
  endfunction

  task automatic drive(input vec_t v);
    halt_i = v.halt; ifu_done_i = v.ifu_done; ifu_err_i = v.ifu_err;
    dec_ls_i = v.dec_ls; dec_multi_i = v.dec_multi; dec_wen_i = v.dec_wen;
    ex_done_i = v.ex_done; lsu_done_i = v.lsu_done; lsu_err_i = v.lsu_err;
  endtask

  function automatic logic [9:0] act_out();
    return {ifu_req_o, ex_start_o, lsu_req_o, reg_we_o, pc_we_o, commit_o, trap_o, busy_o, trap_cause_o};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int exp_ret, exp_stall;
    cur_cause = 2'd0;
    force_halt = 1'b0;

    // Schedule: leading IDLE cycle, then directed instructions, then random ones.
    v = noise(); v.halt = 1'b0; tbl.push_back(v);
    for (int i = 0; i < 3; i++) gen_instr(0, 2, 0, 0, 1, 0, 0, 0, 0);  // 3 ALU, 2-cycle fetch
    gen_instr(0, 3, 0, 0, 1, 0, 0, 0, 0);   // ALU, done on fetch cycle 3
    gen_instr(0, 1, 1, 0, 1, 0, 0, 3, 0);   // load
    gen_instr(0, 1, 1, 1, 0, 0, 0, 4, 0);   // store, ls beats multi, done on last legal cycle
    gen_instr(0, 1, 0, 1, 1, 4, 0, 0, 0);   // mul
    gen_instr(0, 2, 0, 1, 1, 9, 0, 0, 0);   // long EX never times out
    gen_instr(3, 0, 0, 0, 0, 0, 0, 0, 0);   // IF timeout -> cause 2
    gen_instr(2, 2, 0, 0, 0, 0, 0, 0, 0);   // IF done+err -> cause 0
    gen_instr(0, 1, 1, 0, 1, 0, 1, 2, 0);   // LS err -> cause 1
    gen_instr(0, 1, 1, 0, 1, 0, 3, 0, 2);   // LS timeout -> cause 3, then idle
    force_halt = 1'b1;
    gen_instr(0, 1, 1, 0, 1, 0, 0, 2, 3);   // halt held through LS -> WB, IDLE, resume
    force_halt = 1'b0;
    for (int k = 0; k < 120; k++) begin
      gen_instr(pick_kind(), $urandom_range(1, TO_CYC_T), ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 2) == 0), 1'($urandom), $urandom_range(1, 8), pick_kind(),
                $urandom_range(1, TO_CYC_T), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
    end

    // Reset with busy-looking inputs.
    rst = 1'b1;
    v = '0;
    v.ifu_done = 1'b1; v.lsu_done = 1'b1; v.ex_done = 1'b1;
    drive(v);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", -1, 64'(act_out()), 64'd0);
    chk("reset_perf", -1, {perf_cyc_o, perf_ret_o}, 64'd0);
    chk("reset_stall", -1, 64'(perf_stall_o), 64'd0);
    rst = 1'b0;

    exp_ret = 0;
    exp_stall = 0;
    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      chk("outputs", i, 64'(act_out()),
          64'({v.ifu_req, v.ex_start, v.lsu_req, v.reg_we, v.pc_we, v.commit, v.trap, v.busy, v.cause}));
`ifdef CTRL_PERF_EN
      chk("perf_cyc", i, 64'(perf_cyc_o), 64'(i));
      chk("perf_ret", i, 64'(perf_ret_o), 64'(exp_ret));
      chk("perf_stall", i, 64'(perf_stall_o), 64'(exp_stall));
`else
      chk("perf_tied", i, {perf_cyc_o, perf_ret_o ^ perf_stall_o}, 64'd0);
`endif
      exp_ret += int'(v.commit);
      exp_stall += int'(v.stall);
      drive(v);
      @(negedge clk);
    end

    // Reset in the middle of a load: straight back to IDLE, no stray request.
    chk("seq_if_req", -1, 64'({ifu_req_o, busy_o}), 64'b11);
    v = '0; v.ifu_done = 1'b1; drive(v);
    @(negedge clk);
    v = '0; v.dec_ls = 1'b1; v.dec_wen = 1'b1; drive(v);
    @(negedge clk);
    chk("seq_lsu_req", -1, 64'({lsu_req_o, ifu_req_o, busy_o}), 64'b101);
    rst = 1'b1;
    v = '0; v.lsu_done = 1'b1; drive(v);
    @(negedge clk);
    chk("seq_rst_idle", -1, 64'(act_out()), 64'd0);
    chk("seq_rst_perf", -1, {perf_cyc_o, perf_stall_o}, 64'd0);
    rst = 1'b0;
    v = '0; v.lsu_done = 1'b1; drive(v);
    @(negedge clk);
    chk("seq_refetch", -1, 64'(act_out()), 64'b1000_0001_00);
    v = '0; v.lsu_done = 1'b1; v.ex_done = 1'b1; drive(v);
    @(negedge clk);
    chk("seq_no_repulse", -1, 64'(act_out()), 64'b0000_0001_00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
